// File: rtl/mux_sel_sched.sv
// Round-robin scheduler for a downstream 4:1 mux. A granted channel keeps the
// select for DWELL cycles. The grant ends early if the channel's request drops.
module mux_sel_sched #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic [3:0] grant,
  output logic [7:0] rot_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t     state;
  logic [3:0] dwell_cnt;
  logic [1:0] last;
  logic [1:0] next_ch;
  logic       expire;

  // The first requester in the order last+1, last+2, last+3, last wins.
  // The loop runs from the far end, so the nearest hit overwrites the result last.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // In GRANT, last always equals sel, so one search base serves both states.
  always_comb begin
    next_ch = rr_pick(last, req);
    expire  = (dwell_cnt == DWELL_LAST) || !req[sel];
  end

  // NOTE: every register here, including the arbitration pointer, needs an async
  // reset. Sequential state uses non-blocking assignments only, so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'b00;
      sel_valid <= 1'b0;
      grant     <= 4'b0000;
      rot_cnt   <= 8'd0;
      dwell_cnt <= 4'd0;
      last      <= 2'b11;
    end else begin
      case (state)
        IDLE: begin
          if (en && req != 4'b0000) begin
            state     <= GRANT;
            sel       <= next_ch;
            last      <= next_ch;
            sel_valid <= 1'b1;
            grant     <= 4'b0001 << next_ch;
            dwell_cnt <= 4'd0;
            rot_cnt   <= rot_cnt + 8'd1;
          end
        end
        GRANT: begin
          if (!en) begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            grant     <= 4'b0000;
          end else if (expire) begin
            // Dwell expiry and a dropped request count as one expiry event.
            if (req != 4'b0000) begin
              sel       <= next_ch;
              last      <= next_ch;
              grant     <= 4'b0001 << next_ch;
              dwell_cnt <= 4'd0;
              rot_cnt   <= rot_cnt + 8'd1;
            end else begin
              state     <= IDLE;
              sel_valid <= 1'b0;
              grant     <= 4'b0000;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sched.sv
// Bench for mux_sel_sched: table-driven vectors on a DWELL=4 instance, plus
// hand-written sequences for asynchronous reset and the DWELL=1 rot_cnt wrap.
module tb_mux_sel_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [1:0] sel,  sel1;
  logic       sel_valid, sel_valid1;
  logic [3:0] grant, grant1;
  logic [7:0] rot_cnt, rot_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] grant;
    logic [7:0] rot;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mux_sel_sched #(.DWELL(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .sel(sel), .sel_valid(sel_valid), .grant(grant), .rot_cnt(rot_cnt)
  );

  mux_sel_sched #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .sel(sel1), .sel_valid(sel_valid1), .grant(grant1), .rot_cnt(rot_cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic e, input logic [3:0] r, input logic [1:0] s,
                     input logic v, input logic [3:0] g, input logic [7:0] rc);
    vec_t x;
    x.en = e; x.req = r; x.sel = s; x.valid = v; x.grant = g; x.rot = rc;
    vecs.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;

    // Full requests at DWELL=4: each channel holds for 4 edges, then the order wraps to 0.
    for (int i = 0; i < 17; i++)
      add(1'b1, 4'hf, 2'((i / 4) % 4), 1'b1, 4'b0001 << ((i / 4) % 4), 8'(i / 4 + 1));
    add(1'b1, 4'hf, 2'd0, 1'b1, 4'b0001, 8'd5);   // dwell count 1
    add(1'b0, 4'hf, 2'd0, 1'b0, 4'b0000, 8'd5);   // en dropped mid-dwell
    add(1'b1, 4'hf, 2'd1, 1'b1, 4'b0010, 8'd6);   // re-raise: last+1
    add(1'b1, 4'h0, 2'd1, 1'b0, 4'b0000, 8'd6);   // requests gone: early end, back to IDLE
    add(1'b0, 4'hf, 2'd1, 1'b0, 4'b0000, 8'd6);   // IDLE with en=0: sel holds
    add(1'b1, 4'h4, 2'd2, 1'b1, 4'b0100, 8'd7);   // single-cycle request on channel 2
    add(1'b1, 4'h0, 2'd2, 1'b0, 4'b0000, 8'd7);
    add(1'b1, 4'h1, 2'd0, 1'b1, 4'b0001, 8'd8);   // move last to 0
    add(1'b1, 4'h0, 2'd0, 1'b0, 4'b0000, 8'd8);
    add(1'b1, 4'ha, 2'd1, 1'b1, 4'b0010, 8'd9);   // channel 1, count 0
    add(1'b1, 4'ha, 2'd1, 1'b1, 4'b0010, 8'd9);   // count 1
    add(1'b1, 4'h8, 2'd3, 1'b1, 4'b1000, 8'd10);  // req[1] dropped: switch to 3
    add(1'b1, 4'h8, 2'd3, 1'b1, 4'b1000, 8'd10);
    add(1'b1, 4'h0, 2'd3, 1'b0, 4'b0000, 8'd10);
    add(1'b1, 4'h8, 2'd3, 1'b1, 4'b1000, 8'd11);  // lone requester
    for (int i = 0; i < 3; i++) add(1'b1, 4'h8, 2'd3, 1'b1, 4'b1000, 8'd11);
    add(1'b1, 4'h8, 2'd3, 1'b1, 4'b1000, 8'd12);  // re-granted, counted as new
    for (int i = 0; i < 3; i++) add(1'b1, 4'h8, 2'd3, 1'b1, 4'b1000, 8'd12);
    add(1'b1, 4'h0, 2'd3, 1'b0, 4'b0000, 8'd12);  // drop coincides with expiry

    // Reset state
    #12;
    check("reset sel",       32'(sel),       32'd0);
    check("reset sel_valid", 32'(sel_valid), 32'd0);
    check("reset grant",     32'(grant),     32'd0);
    check("reset rot_cnt",   32'(rot_cnt),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after release", 32'(sel_valid), 32'd0);

    foreach (vecs[i]) begin
      en  = vecs[i].en;
      req = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d sel", i),   32'(sel),       32'(vecs[i].sel));
      check($sformatf("vec%0d valid", i), 32'(sel_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d grant", i), 32'(grant),     32'(vecs[i].grant));
      check($sformatf("vec%0d rot", i),   32'(rot_cnt),   32'(vecs[i].rot));
    end

    // Reset asserted between edges while granting
    en = 1'b1; req = 4'hf;
    repeat (3) @(posedge clk);
    #1;
    check("pre-async valid", 32'(sel_valid), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async sel_valid", 32'(sel_valid), 32'd0);
    check("async grant",     32'(grant),     32'd0);
    check("async rot_cnt",   32'(rot_cnt),   32'd0);
    check("async sel",       32'(sel),       32'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; req = 4'h8;
    @(posedge clk);
    #1;
    check("post-reset sel",   32'(sel),       32'd3);
    check("post-reset grant", 32'(grant),     32'h8);
    check("post-reset valid", 32'(sel_valid), 32'd1);
    check("post-reset rot",   32'(rot_cnt),   32'd1);

    // DWELL=1: one grant per edge, sel rotating and rot_cnt wrapping at 256
    do_reset();
    en = 1'b1; req = 4'hf;
    for (int k = 1; k <= 257; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("d1 sel k=%0d", k),   32'(sel1),       32'((k - 1) % 4));
      check($sformatf("d1 valid k=%0d", k), 32'(sel_valid1), 32'd1);
      check($sformatf("d1 rot k=%0d", k),   32'(rot_cnt1),   32'(k % 256));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
